// File: rtl/v60_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : v60_pkg
//  Description : Shared types and constants for the V60 instruction prefetch
//                queue (FSM state encoding, bus transfer size codes).
//  Revision    : 1.0 - initial release
// ============================================================================
package v60_pkg;

    // Prefetch controller states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_DRAIN = 2'd2,
        S_FAULT = 2'd3
    } v60_pf_state_t;

    // Encodings driven on mem_size
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    // Transfer size code matching the bus width in bytes
    function automatic logic [1:0] mem_size_for(input int bus_bytes);
        return (bus_bytes == 2) ? MEM_SIZE_HALF : MEM_SIZE_WORD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/v60_byte_ring.sv
`default_nettype none
// ============================================================================
//  Module      : v60_byte_ring
//  Description : Circular byte store. Accepts one bus beat per cycle with an
//                optional number of leading bytes dropped, and exposes a
//                MAX_INST_BYTES window starting at the read pointer. Unused
//                window bytes read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module v60_byte_ring #(
    parameter int QUEUE_BYTES    = 16,
    parameter int BUS_BYTES      = 4,
    parameter int MAX_INST_BYTES = 8,
    localparam int PTR_W = $clog2(QUEUE_BYTES),
    localparam int LVL_W = $clog2(QUEUE_BYTES + 1),
    localparam int WIN_W = $clog2(MAX_INST_BYTES + 1),
    localparam int OFF_W = $clog2(BUS_BYTES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        wr_en,
    input  logic [8*BUS_BYTES-1:0]      wr_data,
    input  logic [OFF_W-1:0]            wr_skip,
    input  logic                        rd_en,
    input  logic [WIN_W-1:0]            rd_len,
    output logic [8*MAX_INST_BYTES-1:0] win_data,
    output logic [WIN_W-1:0]            win_valid_bytes,
    output logic [LVL_W-1:0]            level
);

    logic [7:0]             mem [QUEUE_BYTES];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       wr_cnt;
    logic [LVL_W-1:0]       rd_cnt;
    logic [8*BUS_BYTES-1:0] wr_shifted;

    // Align the beat so its first kept byte lands at the write pointer
    always_comb begin
        wr_shifted = wr_data >> {wr_skip, 3'b000};
        wr_cnt     = wr_en ? (LVL_W'(BUS_BYTES) - LVL_W'(wr_skip)) : '0;
        rd_cnt     = rd_en ? LVL_W'(rd_len) : '0;
        win_valid_bytes = (level > LVL_W'(MAX_INST_BYTES)) ? WIN_W'(MAX_INST_BYTES)
                                                           : WIN_W'(level);
    end

    // Window taps read through the pointer wrap transparently
    for (genvar i = 0; i < MAX_INST_BYTES; i++) begin : g_win
        assign win_data[8*i +: 8] = (WIN_W'(i) < win_valid_bytes)
                                    ? mem[rd_ptr + PTR_W'(i)] : 8'h00;
    end

    // Pointers and fill level; clear discards everything including this cycle's traffic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr_cnt);
            rd_ptr <= rd_ptr + PTR_W'(rd_cnt);
            level  <= level + wr_cnt - rd_cnt;
        end
    end

    // Byte storage; contents need no reset because the window masks by level
    always_ff @(posedge clk) begin
        for (int j = 0; j < BUS_BYTES; j++) begin
            if (!clear && (LVL_W'(j) < wr_cnt)) begin
                mem[wr_ptr + PTR_W'(j)] <= wr_shifted[8*j +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/v60_prefetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : v60_prefetch_queue
//  Description : Instruction prefetch unit. Issues aligned bus reads ahead of
//                execution into a byte ring and presents a decoder window at
//                win_pc. Handles variable-length consume, branch flush to any
//                byte address and bus-error fault tagging.
//  Revision    : 1.0 - initial release
// ============================================================================
module v60_prefetch_queue
    import v60_pkg::*;
#(
    parameter int                   ADDR_WIDTH     = 32,
    parameter int                   BUS_BYTES      = 4,
    parameter int                   QUEUE_BYTES    = 16,
    parameter int                   MAX_INST_BYTES = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0,
    localparam int LVL_W = $clog2(QUEUE_BYTES + 1),
    localparam int WIN_W = $clog2(MAX_INST_BYTES + 1),
    localparam int OFF_W = $clog2(BUS_BYTES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        fetch_en,
    input  logic                        flush,
    input  logic [ADDR_WIDTH-1:0]       flush_pc,
    output logic                        mem_req,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic [1:0]                  mem_size,
    input  logic [8*BUS_BYTES-1:0]      mem_rdata,
    input  logic                        mem_ready,
    input  logic                        mem_err,
    output logic [8*MAX_INST_BYTES-1:0] win_data,
    output logic [WIN_W-1:0]            win_valid_bytes,
    output logic [ADDR_WIDTH-1:0]       win_pc,
    input  logic                        consume,
    input  logic [WIN_W-1:0]            consume_len,
    output logic                        fault,
    output logic [ADDR_WIDTH-1:0]       fault_addr,
    output logic [LVL_W-1:0]            level
);

    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK    = ~ADDR_WIDTH'(BUS_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] RESET_ALIGNED = RESET_PC & ALIGN_MASK;
    localparam logic [OFF_W-1:0]      RESET_SKIP    = RESET_PC[OFF_W-1:0];

    v60_pf_state_t         state;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [OFF_W-1:0]      skip;
    logic [WIN_W-1:0]      take;
    logic [LVL_W-1:0]      free_now;
    logic [LVL_W-1:0]      free_after;
    logic                  ring_wr;
    logic                  issue_ok;
    logic                  reissue_ok;

    assign mem_size = mem_size_for(BUS_BYTES);

    // Space checks use the registered level; a completing beat is counted
    // before deciding on a back-to-back request so the ring never overflows
    always_comb begin
        take       = '0;
        if (consume) begin
            take = (consume_len > win_valid_bytes) ? win_valid_bytes : consume_len;
        end
        free_now   = LVL_W'(QUEUE_BYTES) - level;
        free_after = free_now - (LVL_W'(BUS_BYTES) - LVL_W'(skip));
        ring_wr    = (state == S_REQ) && mem_ready && !mem_err && !flush;
        issue_ok   = fetch_en && (free_now >= LVL_W'(BUS_BYTES));
        reissue_ok = fetch_en && (free_after >= LVL_W'(BUS_BYTES));
    end

    v60_byte_ring #(
        .QUEUE_BYTES    (QUEUE_BYTES),
        .BUS_BYTES      (BUS_BYTES),
        .MAX_INST_BYTES (MAX_INST_BYTES)
    ) u_ring (
        .clk             (clk),
        .rst_n           (rst_n),
        .clear           (flush),
        .wr_en           (ring_wr),
        .wr_data         (mem_rdata),
        .wr_skip         (skip),
        .rd_en           (consume),
        .rd_len          (take),
        .win_data        (win_data),
        .win_valid_bytes (win_valid_bytes),
        .level           (level)
    );

    // Fetch controller: request issue, drain after flush, fault capture, PC tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            fetch_addr <= RESET_ALIGNED;
            skip       <= RESET_SKIP;
            fault      <= 1'b0;
            fault_addr <= '0;
            win_pc     <= RESET_PC;
        end else if (flush) begin
            fetch_addr <= flush_pc & ALIGN_MASK;
            skip       <= flush_pc[OFF_W-1:0];
            win_pc     <= flush_pc;
            fault      <= 1'b0;
            fault_addr <= '0;
            case (state)
                // An outstanding request cannot be withdrawn; wait it out
                S_REQ, S_DRAIN: begin
                    if (mem_ready) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                    end else begin
                        state   <= S_DRAIN;
                    end
                end
                default: begin
                    if (fetch_en) begin
                        state    <= S_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= flush_pc & ALIGN_MASK;
                    end else begin
                        state    <= S_IDLE;
                        mem_req  <= 1'b0;
                    end
                end
            endcase
        end else begin
            if (consume) begin
                win_pc <= win_pc + ADDR_WIDTH'(take);
            end
            case (state)
                S_IDLE: begin
                    if (issue_ok) begin
                        state    <= S_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_addr;
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        if (mem_err) begin
                            state      <= S_FAULT;
                            mem_req    <= 1'b0;
                            fault      <= 1'b1;
                            fault_addr <= mem_addr;
                        end else begin
                            fetch_addr <= fetch_addr + ADDR_WIDTH'(BUS_BYTES);
                            skip       <= '0;
                            if (reissue_ok) begin
                                mem_addr <= fetch_addr + ADDR_WIDTH'(BUS_BYTES);
                            end else begin
                                state    <= S_IDLE;
                                mem_req  <= 1'b0;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (mem_ready) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    // Faulted: hold until a flush redirects fetch
                end
            endcase
        end
    end

    // A decoder asking for more bytes than the window shows is a core bug
    a_consume_len : assert property (@(posedge clk) disable iff (!rst_n)
        consume |-> (consume_len <= win_valid_bytes));

endmodule
`default_nettype wire

// File: doc/v60_prefetch_queue.md
Name: v60_prefetch_queue

Overview:
- Parametrised instruction prefetch unit for the V60 core. It replaces the single-word fetch/inst_buffer path with a byte-granular circular queue.
- Issues aligned bus reads ahead of execution and presents a sliding window of up to MAX_INST_BYTES bytes at the current PC to the decoder.
- Supports variable-length consumption, branch flush to any byte address, and fetch-fault tagging.
- Sits between the core control FSM and the memory request port.

Parameters:
- ADDR_WIDTH, 32, address width.
- BUS_BYTES, 4, bytes per bus read; 2 or 4.
- QUEUE_BYTES, 16, queue capacity; power of 2, >= 2*BUS_BYTES and >= MAX_INST_BYTES.
- MAX_INST_BYTES, 8, decoder window width in bytes.
- RESET_PC, 0, fetch start address after reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fetch_en  in  1  permit new bus requests
- flush  in  1  discard queue; restart at flush_pc
- flush_pc  in  ADDR_WIDTH  new PC, any byte alignment
- mem_req  out  1  read request
- mem_addr  out  ADDR_WIDTH  BUS_BYTES-aligned read address
- mem_size  out  2  01 = halfword (BUS_BYTES=2), 10 = word (BUS_BYTES=4)
- mem_rdata  in  8*BUS_BYTES  read data, little-endian
- mem_ready  in  1  completes request this cycle
- mem_err  in  1  bus error; qualified by mem_ready
- win_data  out  8*MAX_INST_BYTES  byte i = instruction byte at win_pc+i
- win_valid_bytes  out  clog2(MAX_INST_BYTES+1)  valid bytes in window
- win_pc  out  ADDR_WIDTH  address of win_data byte 0
- consume  in  1  retire consume_len bytes
- consume_len  in  clog2(MAX_INST_BYTES+1)  1..win_valid_bytes
- fault  out  1  fetch stopped on bus error
- fault_addr  out  ADDR_WIDTH  aligned address of the faulting read
- level  out  clog2(QUEUE_BYTES+1)  bytes held in the queue

Behaviour:
- Reset values:
  - mem_req=0, mem_addr=0, win_valid_bytes=0, win_data=0.
  - win_pc=RESET_PC, fault=0, fault_addr=0, level=0.
  - Internal fetch address = RESET_PC aligned down; skip count = RESET_PC mod BUS_BYTES.
- States: S_IDLE, S_REQ, S_DRAIN, S_FAULT (enum in package).
- S_IDLE: go to S_REQ and assert mem_req when fetch_en=1, no flush, and (QUEUE_BYTES - level) >= BUS_BYTES, using the registered level.
- S_REQ:
  - mem_req=1; mem_addr and mem_size are held stable until mem_ready. Requests are never withdrawn.
  - On mem_ready with mem_err=0: write BUS_BYTES minus skip bytes, drop the skip leading bytes, clear skip, and advance the fetch address by BUS_BYTES (wraps modulo 2^ADDR_WIDTH).
  - Then go to S_REQ again if the issue condition still holds (back-to-back, no bubble); otherwise go to S_IDLE.
  - On mem_ready with mem_err=1: write no bytes; set fault_addr=mem_addr and fault=1; go to S_FAULT.
- S_DRAIN:
  - Entered when flush arrives in S_REQ without mem_ready.
  - Keeps mem_req and the old address until mem_ready, then discards data and error and goes to S_IDLE with the new fetch address.
- S_FAULT: no requests. Queued bytes stay consumable. Only flush leaves this state; flush clears fault and fault_addr.
- Data latency: bytes from a mem_ready in cycle N are visible in the window at N+1.
- Window outputs:
  - win_valid_bytes = min(level, MAX_INST_BYTES).
  - win_data bytes at index >= win_valid_bytes read 0.
- Consume: on consume=1, the read pointer and win_pc advance by consume_len at the next edge.
  - consume_len > win_valid_bytes is illegal (assertion); RTL clamps it to win_valid_bytes.
- Same-cycle fill and consume: level_next = level + written - consumed. Never exceeds QUEUE_BYTES.
- Flush in cycle N, at N+1:
  - level=0, win_pc=flush_pc.
  - Fetch address = flush_pc aligned down; skip = flush_pc mod BUS_BYTES.
  - mem_req at N+1 only if the FSM was not in S_REQ/S_DRAIN and fetch_en=1.
- Priority: flush overrides consume and any write in the same cycle.
  - Flush during S_DRAIN updates the target only.
  - Flush together with mem_ready in S_REQ: the data is discarded and the FSM goes to S_IDLE, not S_DRAIN.
- Queue pointers wrap modulo QUEUE_BYTES; the window read spans the wrap seamlessly.
- Async reset mid-request drops mem_req immediately; no transaction completion is required.

Decomposition:
- v60_pkg: v60_pf_state_t enum; MEM_SIZE_BYTE/HALF/WORD constants.
- Sub-module v60_byte_ring: circular byte store with a BUS_BYTES-wide masked write, a MAX_INST_BYTES read window, pointers and level.
- The parent holds the FSM, address and skip logic, and fault logic.

Test Plan:
- Reset, fetch_en=1, memory ready-every-cycle returning 0x03020100, 0x07060504 -> two requests at 0x0 and 0x4; after the second completes, win_valid_bytes=8, win_data=0x0706050403020100, win_pc=0.
- No consume -> exactly 4 requests (0x0-0xC), level=16, mem_req low. Consume 3 -> level=13, still no request. Consume 1 -> level=12, mem_req next cycle with mem_addr=0x10.
- Flush with flush_pc=0x1002 while idle -> next cycle mem_addr=0x1000. Data 0xDDCCBBAA -> win_valid_bytes=2, win_data[15:0]=0xDDCC, win_pc=0x1002.
- Flush to 0x2000 while a request to 0x8 waits 3 cycles for ready -> mem_addr stays 0x8 until ready; data discarded, level=0; then a request at 0x2000.
- mem_err on the read of 0x8 after 0x0 and 0x4 succeeded -> fault=1, fault_addr=0x8, no further mem_req; 8 bytes still consumable; flush to 0x100 clears fault and fetches 0x100.
- RESET_PC=0xFFFFFFF8, continuous consume of 3 bytes -> fetch address wraps 0xFFFFFFFC to 0x0; ring pointers wrap; window bytes stay contiguous and correct across both wraps.
